writeback_unit: RTL and testbench

Writeback stage directly upstream of the 32 x 64-bit register bank; it owns that bank's single write port. It merges single-cycle ALU results and buffered load results into one registered write per cycle. It also keeps a 32-bit pending-write scoreboard for issue-side hazard checks. Its outputs connect straight to the bank's write enable, write address (address port 3) and write data.

---
 rtl/writeback_if.sv | 40 ++++
 rtl/writeback_unit.sv | 136 +++++++++++++
 tb/tb_writeback_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/writeback_if.sv
// Bus bundle between the issue/execute side and the writeback unit:
// ALU result, load-result handshake, issue marking, register-bank write
// port and status outputs.
interface writeback_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) ();
    logic                         alu_valid;
    logic [ADDR_WIDTH-1:0]        alu_address;
    logic [DATA_WIDTH-1:0]        alu_data;
    logic                         mem_valid;
    logic                         mem_ready;
    logic [ADDR_WIDTH-1:0]        mem_address;
    logic [DATA_WIDTH-1:0]        mem_data;
    logic                         issue_valid;
    logic [ADDR_WIDTH-1:0]        issue_address;
    logic                         alu_stall;
    logic                         write;
    logic [ADDR_WIDTH-1:0]        write_address;
    logic [DATA_WIDTH-1:0]        write_data;
    logic [(1<<ADDR_WIDTH)-1:0]   busy;
    logic [2:0]                   fifo_count;
    logic                         overrun;

    modport master (
        output alu_valid, alu_address, alu_data,
        output mem_valid, mem_address, mem_data,
        output issue_valid, issue_address,
        input  mem_ready, alu_stall, write, write_address, write_data,
        input  busy, fifo_count, overrun
    );

    modport slave (
        input  alu_valid, alu_address, alu_data,
        input  mem_valid, mem_address, mem_data,
        input  issue_valid, issue_address,
        output mem_ready, alu_stall, write, write_address, write_data,
        output busy, fifo_count, overrun
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage owning the register bank's single write port. Merges
// single-cycle ALU results with buffered load results into one registered
// write per cycle, with starvation protection for the load FIFO, and keeps
// a pending-write scoreboard for issue-side hazard checks.
module writeback_unit #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clock,
    input  logic       reset,
    writeback_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int NREG  = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    // Load-result buffer storage (contents need no reset; pointers do)
    logic [ADDR_WIDTH-1:0] fifo_addr_r [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic [STV_W-1:0]      starve_cnt_r;
    logic                  alu_stall_r;
    logic                  overrun_r;
    logic                  write_r;
    logic [ADDR_WIDTH-1:0] write_address_r;
    logic [DATA_WIDTH-1:0] write_data_r;
    logic [NREG-1:0]       busy_r;

    logic                  fifo_nonempty_s;
    logic                  mem_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  alu_win_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [DATA_WIDTH-1:0] win_data_s;
    logic [NREG-1:0]       clear_mask_s;
    logic [NREG-1:0]       set_mask_s;
    logic [NREG-1:0]       busy_next_s;
    logic [STV_W-1:0]      starve_next_s;
    logic [CNT_W-1:0]      count_next_s;

    // Arbitration, FIFO bookkeeping and scoreboard next-state, all from registered state
    always_comb begin
        fifo_nonempty_s = (count_r != {CNT_W{1'b0}});
        mem_ready_s     = !reset && (count_r < DEPTH_C);
        push_s          = bus.mem_valid && mem_ready_s;
        // FIFO head wins when starving the ALU out, or when the ALU is idle
        pop_s           = fifo_nonempty_s && (alu_stall_r || !bus.alu_valid);
        alu_win_s       = bus.alu_valid && !pop_s;

        if (pop_s) begin
            win_addr_s = fifo_addr_r[rd_ptr_r];
            win_data_s = fifo_data_r[rd_ptr_r];
        end else if (alu_win_s) begin
            win_addr_s = bus.alu_address;
            win_data_s = bus.alu_data;
        end else begin
            win_addr_s = write_address_r;
            win_data_s = write_data_r;
        end

        // A same-edge set overrides the clear: the new producer stays outstanding
        clear_mask_s = (pop_s || alu_win_s)
                     ? ({{(NREG-1){1'b0}}, 1'b1} << win_addr_s) : {NREG{1'b0}};
        set_mask_s   = bus.issue_valid
                     ? ({{(NREG-1){1'b0}}, 1'b1} << bus.issue_address) : {NREG{1'b0}};
        busy_next_s  = (busy_r & ~clear_mask_s) | set_mask_s;

        if (pop_s || !fifo_nonempty_s) begin
            starve_next_s = {STV_W{1'b0}};
        end else if (alu_win_s && (starve_cnt_r != LIMIT_C)) begin
            starve_next_s = starve_cnt_r + STV_W'(1);
        end else begin
            starve_next_s = starve_cnt_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Capture pushed load results into the slot at the write pointer
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= bus.mem_address;
            fifo_data_r[wr_ptr_r] <= bus.mem_data;
        end
    end

    // Registered write port, pointers, counters, stall/error flags and scoreboard
    always_ff @(posedge clock) begin
        if (reset) begin
            write_r         <= 1'b0;
            write_address_r <= {ADDR_WIDTH{1'b0}};
            write_data_r    <= {DATA_WIDTH{1'b0}};
            busy_r          <= {NREG{1'b0}};
            count_r         <= {CNT_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            wr_ptr_r        <= {PTR_W{1'b0}};
            starve_cnt_r    <= {STV_W{1'b0}};
            alu_stall_r     <= 1'b0;
            overrun_r       <= 1'b0;
        end else begin
            write_r         <= pop_s || alu_win_s;
            write_address_r <= win_addr_s;
            write_data_r    <= win_data_s;
            busy_r          <= busy_next_s;
            count_r         <= count_next_s;
            rd_ptr_r        <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            wr_ptr_r        <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            starve_cnt_r    <= starve_next_s;
            alu_stall_r     <= (starve_next_s == LIMIT_C);
            // ALU result offered while it was told to stall is dropped and flagged
            overrun_r       <= overrun_r || (bus.alu_valid && alu_stall_r && pop_s);
        end
    end

    assign bus.mem_ready     = mem_ready_s;
    assign bus.alu_stall     = alu_stall_r;
    assign bus.write         = write_r;
    assign bus.write_address = write_address_r;
    assign bus.write_data    = write_data_r;
    assign bus.busy          = busy_r;
    assign bus.fifo_count    = 3'(count_r);
    assign bus.overrun       = overrun_r;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    writeback_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

    writeback_unit #(
        .DATA_WIDTH(64), .ADDR_WIDTH(5), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_address = 5'd0; bus.alu_data = 64'd0;
        bus.mem_valid = 1'b0; bus.mem_address = 5'd0; bus.mem_data = 64'd0;
        bus.issue_valid = 1'b0; bus.issue_address = 5'd0;

        // Reset state
        step(); step();
        check_eq("rst_write", 64'(bus.write), 64'd0);
        check_eq("rst_waddr", 64'(bus.write_address), 64'd0);
        check_eq("rst_wdata", bus.write_data, 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_count", 64'(bus.fifo_count), 64'd0);
        check_eq("rst_stall", 64'(bus.alu_stall), 64'd0);
        check_eq("rst_overrun", 64'(bus.overrun), 64'd0);
        check_eq("rst_ready", 64'(bus.mem_ready), 64'd0);
        reset = 1'b0;
        #1;
        check_eq("ready_after_rst", 64'(bus.mem_ready), 64'd1);

        // ALU path: presented in one cycle, written in the next
        bus.alu_valid = 1'b1; bus.alu_address = 5'd7; bus.alu_data = 64'h0123_4567_89AB_CDEF;
        step();
        bus.alu_valid = 1'b0;
        check_eq("alu_write", 64'(bus.write), 64'd1);
        check_eq("alu_waddr", 64'(bus.write_address), 64'd7);
        check_eq("alu_wdata", bus.write_data, 64'h0123_4567_89AB_CDEF);
        step();
        check_eq("alu_idle_write", 64'(bus.write), 64'd0);
        check_eq("alu_hold_waddr", 64'(bus.write_address), 64'd7);
        check_eq("alu_hold_wdata", bus.write_data, 64'h0123_4567_89AB_CDEF);

        // FIFO fill under continuous ALU traffic
        bus.alu_valid = 1'b1; bus.alu_address = 5'd20; bus.alu_data = 64'h2020;
        for (int k = 1; k <= 4; k++) begin
            check_eq("fill_ready", 64'(bus.mem_ready), 64'd1);
            bus.mem_valid = 1'b1; bus.mem_address = 5'(k); bus.mem_data = 64'hA0 + 64'(k);
            step();
            check_eq("fill_alu_write", 64'(bus.write_address), 64'd20);
        end
        check_eq("full_count", 64'(bus.fifo_count), 64'd4);
        check_eq("full_ready", 64'(bus.mem_ready), 64'd0);
        bus.mem_address = 5'd5; bus.mem_data = 64'hA5;
        step();
        check_eq("full_no_push", 64'(bus.fifo_count), 64'd4);
        check_eq("full_alu_write", 64'(bus.write_address), 64'd20);
        bus.alu_valid = 1'b0;
        step();
        // Head (1) popped; room again so load 5 is pushed this cycle
        check_eq("ready_after_pop", 64'(bus.mem_ready), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            check_eq("drain_write", 64'(bus.write), 64'd1);
            check_eq("drain_waddr", 64'(bus.write_address), 64'(k));
            check_eq("drain_wdata", bus.write_data, 64'hA0 + 64'(k));
            step();
            bus.mem_valid = 1'b0;
        end
        check_eq("drain_done_write", 64'(bus.write), 64'd0);
        check_eq("drain_done_count", 64'(bus.fifo_count), 64'd0);

        // Starvation: one load waits behind 8 ALU wins, then takes the port
        bus.mem_valid = 1'b1; bus.mem_address = 5'd12; bus.mem_data = 64'hC12;
        step();
        bus.mem_valid = 1'b0;
        check_eq("starve_count", 64'(bus.fifo_count), 64'd1);
        bus.alu_valid = 1'b1; bus.alu_address = 5'd22;
        for (int i = 1; i <= 12; i++) begin
            check_eq("starve_stall", 64'(bus.alu_stall), (i == 9) ? 64'd1 : 64'd0);
            bus.alu_data = 64'hD00 + 64'(i);
            step();
            check_eq("starve_write", 64'(bus.write), 64'd1);
            check_eq("starve_waddr", 64'(bus.write_address), (i == 9) ? 64'd12 : 64'd22);
            check_eq("starve_wdata", bus.write_data, (i == 9) ? 64'hC12 : 64'hD00 + 64'(i));
        end
        bus.alu_valid = 1'b0;
        check_eq("starve_overrun", 64'(bus.overrun), 64'd1);
        check_eq("starve_empty", 64'(bus.fifo_count), 64'd0);

        // Scoreboard: set on issue, set beats same-edge clear, plain clear
        step();
        bus.issue_valid = 1'b1; bus.issue_address = 5'd9;
        step();
        bus.issue_valid = 1'b0;
        check_eq("busy9_set", 64'(bus.busy), 64'h0000_0200);
        step();
        step();
        bus.alu_valid = 1'b1; bus.alu_address = 5'd9; bus.alu_data = 64'h9999;
        bus.issue_valid = 1'b1; bus.issue_address = 5'd9;
        step();
        bus.issue_valid = 1'b0;
        check_eq("reissue_waddr", 64'(bus.write_address), 64'd9);
        check_eq("reissue_busy9", 64'(bus.busy[9]), 64'd1);
        bus.alu_data = 64'h9998;
        step();
        bus.alu_valid = 1'b0;
        check_eq("clear_write", 64'(bus.write), 64'd1);
        check_eq("clear_waddr", 64'(bus.write_address), 64'd9);
        check_eq("clear_busy", 64'(bus.busy), 64'd0);

        // Reset mid-drain: 3 entries queued and one register pending
        bus.alu_valid = 1'b1; bus.alu_address = 5'd30; bus.alu_data = 64'h3030;
        bus.issue_valid = 1'b1; bus.issue_address = 5'd13;
        for (int k = 0; k < 3; k++) begin
            bus.mem_valid = 1'b1; bus.mem_address = 5'd13 + 5'(k); bus.mem_data = 64'hE0 + 64'(k);
            step();
            bus.issue_valid = 1'b0;
        end
        bus.mem_valid = 1'b0;
        check_eq("pre_rst_count", 64'(bus.fifo_count), 64'd3);
        check_eq("pre_rst_busy", 64'(bus.busy), 64'h0000_2000);
        bus.alu_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_eq("post_rst_count", 64'(bus.fifo_count), 64'd0);
        check_eq("post_rst_busy", 64'(bus.busy), 64'd0);
        check_eq("post_rst_write", 64'(bus.write), 64'd0);
        check_eq("post_rst_ready", 64'(bus.mem_ready), 64'd1);
        check_eq("post_rst_overrun", 64'(bus.overrun), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("no_stale_write", 64'(bus.write), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
